fifo_push_arbiter: RTL and testbench

- Shares the push side of one cva5_fifo instance between NUM_REQ requesters.
- Uses round-robin arbitration at packet granularity: a multi-beat packet keeps the grant until its last beat is enqueued.
- Tags every enqueued beat with the source requester id, so the consumer can demultiplex.
- Sits between producer units and the fifo; observes the fifo's full and pop signals to allow continuous enqueue when the fifo is full.

---
 rtl/fifo_push_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin, packet-locked arbiter that shares one fifo push port among NUM_REQ
// producers. Every enqueued beat is tagged with its source id.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_pop,
  output logic                          fifo_push,
  output logic                          fifo_potential_push,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_data_in,
  output logic                          locked,
  output logic [ID_W-1:0]               owner_id
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]       owner_reg, owner_next;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ID_W:0]         cand;
  logic [ID_W-1:0]       arb_winner, sel_id, sel_id_inc;
  logic                  space, sel_valid, sel_last, push;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = push && (sel_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the highest rotation offset down so the first valid after rr_ptr wins.
  always_comb begin
    arb_winner = rr_ptr_reg;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[cand[ID_W-1:0]]) arb_winner = cand[ID_W-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    space       = ~fifo_full | fifo_pop;
    sel_id      = (state_reg == LOCKED) ? owner_reg : arb_winner;
    sel_valid   = req_valid[sel_id];
    sel_last    = req_last[sel_id];
    sel_id_inc  = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);
    push        = space & sel_valid & ~rst;
    if (push) begin
      if (sel_last) begin
        state_next  = ARB;
        rr_ptr_next = sel_id_inc;
      end else begin
        state_next = LOCKED;
        owner_next = sel_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  assign fifo_push           = push;
  assign fifo_potential_push = push;
  assign fifo_data_in        = {sel_id, data_arr[sel_id]};
  assign locked              = (state_reg == LOCKED);
  assign owner_id            = owner_reg;

  a_push_space : assert property (@(posedge clk) disable iff (rst) fifo_push |-> space);
  a_ready_oh0  : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_lock_owner : assert property (@(posedge clk) disable iff (rst)
    (state_reg == LOCKED) |-> ((req_ready & ~(NUM_REQ'(1) << owner_reg)) == '0));

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_proto
      a_hold : assert property (@(posedge clk) disable iff (rst)
        (req_valid[gi] && !req_ready[gi]) |=>
          (req_valid[gi] && $stable(req_last[gi]) &&
           $stable(req_data[gi*DATA_WIDTH +: DATA_WIDTH])));
    end
  endgenerate

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: vector table, hand-written corner sequences, and a
// randomized run checked against a queue-free behavioural arbiter model.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_pop, fifo_push, fifo_potential_push, locked;
  logic [DW+1:0]   fifo_data_in;
  logic [1:0]      owner_id;

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_pop(fifo_pop),
    .fifo_push(fifo_push), .fifo_potential_push(fifo_potential_push),
    .fifo_data_in(fifo_data_in), .locked(locked), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (fifo_push === 1'b1)
      $display("beat t=%0t id=%0d data=%h ready=%b", $time, fifo_data_in[DW+1:DW],
               fifo_data_in[DW-1:0], req_ready);

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       p;
    logic [3:0] r;
    logic       push;
    int         id;
    logic       lk;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] dconst [N];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic f, input logic p);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    fifo_pop  = p;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, 64'(req_ready), 64'(0));
    chk({name, "_push"}, 64'(fifo_push), 64'(0));
    chk({name, "_ppush"}, 64'(fifo_potential_push), 64'(0));
  endtask

  // Inputs are held during the first reset cycle so no pending requester sees a change.
  task automatic clean_reset(input logic [3:0] v);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("crst");
    nxt();
    set_in(v, 4'hF, 1'b0, 1'b0);
    nxt();
    rst = 1'b0;
  endtask

  logic [DW+1:0] ed;
  logic [3:0]    pv, pl, acc, er;
  logic [31:0]   pd [N];
  int            m_owner, m_pref, mc, mj;
  logic          sp, ep;

  initial begin
    for (int i = 0; i < N; i++) dconst[i] = 32'hA500_0000 + 32'h0011_1100 * (i + 1) + i;
    req_data = {dconst[3], dconst[2], dconst[1], dconst[0]};

    tbl[0]  = '{4'hF, 4'hF,    1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
    tbl[1]  = '{4'hF, 4'hF,    1'b0, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
    tbl[2]  = '{4'hF, 4'b1101, 1'b0, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
    tbl[3]  = '{4'hF, 4'b1101, 1'b0, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
    tbl[4]  = '{4'hF, 4'b1101, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
    tbl[5]  = '{4'hF, 4'b1101, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
    tbl[6]  = '{4'hF, 4'b1101, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 1'b1};
    tbl[7]  = '{4'hF, 4'hF,    1'b0, 1'b0, 4'b0010, 1'b1, 1, 1'b1};
    tbl[8]  = '{4'hF, 4'hF,    1'b0, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
    tbl[9]  = '{4'hF, 4'hF,    1'b1, 1'b0, 4'b0000, 1'b0, 3, 1'b0};
    tbl[10] = '{4'hF, 4'hF,    1'b1, 1'b0, 4'b0000, 1'b0, 3, 1'b0};
    tbl[11] = '{4'hF, 4'hF,    1'b1, 1'b0, 4'b0000, 1'b0, 3, 1'b0};
    tbl[12] = '{4'hF, 4'hF,    1'b1, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
    tbl[13] = '{4'hF, 4'hF,    1'b0, 1'b1, 4'b0001, 1'b1, 0, 1'b0};

    rst = 1'b1;
    set_in(4'hF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("rst1");
    @(negedge clk);
    chk_idle("rst2");
    chk("rst_locked", 64'(locked), 64'(0));
    nxt();
    rst = 1'b0;

    foreach (tbl[t]) begin
      set_in(tbl[t].v, tbl[t].l, tbl[t].f, tbl[t].p);
      @(negedge clk);
      ed = {2'(tbl[t].id), dconst[tbl[t].id]};
      chk("tbl_ready", 64'(req_ready), 64'(tbl[t].r));
      chk("tbl_push", 64'(fifo_push), 64'(tbl[t].push));
      chk("tbl_ppush", 64'(fifo_potential_push), 64'(tbl[t].push));
      chk("tbl_data", 64'(fifo_data_in), 64'(ed));
      chk("tbl_locked", 64'(locked), 64'(tbl[t].lk));
      if (tbl[t].lk) chk("tbl_owner", 64'(owner_id), 64'(tbl[t].id));
      nxt();
    end

    // Owner bubble: req2 locks, disappears for two cycles, then finishes its packet.
    clean_reset(4'h0);
    set_in(4'b0100, 4'b1011, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_grant", 64'(req_ready), 64'(4'b0100));
    nxt();
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0001, 4'b1011, 1'b0, 1'b0);
      @(negedge clk);
      chk_idle("bub_hold");
      chk("bub_locked", 64'(locked), 64'(1));
      chk("bub_owner", 64'(owner_id), 64'(2));
      chk("bub_data", 64'(fifo_data_in), 64'({2'd2, dconst[2]}));
      nxt();
    end
    set_in(4'b0101, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_resume", 64'(req_ready), 64'(4'b0100));
    chk("bub_resume_lk", 64'(locked), 64'(1));
    nxt();
    set_in(4'b0001, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_release", 64'(req_ready), 64'(4'b0001));
    chk("bub_unlocked", 64'(locked), 64'(0));
    nxt();

    // Reset in the middle of req1's packet.
    set_in(4'b0111, 4'b1101, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_beat1", 64'(req_ready), 64'(4'b0010));
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_inrst");
    chk("mid_prelock", 64'(locked), 64'(1));
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_unlocked", 64'(locked), 64'(0));
    chk("mid_grant0", 64'(req_ready), 64'(4'b0001));
    chk("mid_data", 64'(fifo_data_in), 64'({2'd0, dconst[0]}));
    nxt();

    // Randomized producers that honour the hold-until-ready rule.
    clean_reset(4'h0);
    m_owner = -1;
    m_pref  = 0;
    pv = '0; pl = '0; acc = '0;
    for (int i = 0; i < N; i++) pd[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] || acc[i]) begin
          pv[i] = ($urandom_range(0, 9) < 6);
          pl[i] = 1'($urandom_range(0, 1));
          pd[i] = $urandom;
        end
        req_data[i*DW +: DW] = pd[i];
      end
      set_in(pv, pl, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      @(negedge clk);
      sp = !fifo_full || fifo_pop;
      mc = -1;
      if (m_owner >= 0) begin
        if (pv[m_owner]) mc = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          mj = (m_pref + k) % N;
          if (mc < 0 && pv[mj]) mc = mj;
        end
      end
      ep = sp && (mc >= 0);
      er = ep ? 4'(1 << mc) : 4'h0;
      chk("rnd_ready", 64'(req_ready), 64'(er));
      chk("rnd_push", 64'(fifo_push), 64'(ep));
      chk("rnd_ppush", 64'(fifo_potential_push), 64'(ep));
      chk("rnd_locked", 64'(locked), 64'(m_owner >= 0));
      if (m_owner >= 0) chk("rnd_owner", 64'(owner_id), 64'(m_owner));
      if (mc >= 0 || m_owner >= 0) begin
        mj = (mc >= 0) ? mc : m_owner;
        ed = {2'(mj), pd[mj]};
        chk("rnd_data", 64'(fifo_data_in), 64'(ed));
      end
      if (ep) begin
        if (pl[mc]) begin
          m_owner = -1;
          m_pref  = (mc + 1) % N;
        end else begin
          m_owner = mc;
        end
      end
      acc = req_ready;
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
